// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
//
// Main decoder plus ALU decoder for the single-cycle MIPS datapath. The
// opcode/funct fields and the ALU zero flag are decoded combinationally, and
// the resulting control word is captured into output registers on every
// rising clock edge. This gives exactly one cycle of latency. Reset puts the
// outputs into a safe no-op state with no register or memory write.
//
// Ports:
//   clock_i       rising-edge clock
//   reset_n_i     asynchronous, active-low reset
//   opcode_i      instruction[31:26]
//   funct_i       instruction[5:0], only looked at when opcode_i == 0
//   zero_i        ALU result == 0 flag (only affects BEQ)
//   rf_we_o       register-file write enable
//   sel_wa_o      write address: 00 rt, 01 rd, 10 $31
//   sel_alu_b_o   ALU B operand: 0 register rt, 1 sign-extended immediate
//   dmem_we_o     data-memory write enable
//   sel_result_o  write-back: 00 dmem data, 01 ALU result, 10 PC+4
//   sel_pc_o      next PC: 00 PC+4, 01 branch, 10 jump, 11 register (jr)
//   alu_ctrl_o    ALU operation code
// ---------------------------------------------------------------------------
module control_unit (
    input  logic       clock_i,
    input  logic       reset_n_i,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    output logic       rf_we_o,
    output logic [1:0] sel_wa_o,
    output logic       sel_alu_b_o,
    output logic       dmem_we_o,
    output logic [1:0] sel_result_o,
    output logic [1:0] sel_pc_o,
    output logic [3:0] alu_ctrl_o
);

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_XOR = 4'b0011,
        ALU_NOR = 4'b0100,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_SLL = 4'b1000,
        ALU_SRL = 4'b1001,
        ALU_SRA = 4'b1010
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [1:0] WA_RT    = 2'b00;
    localparam logic [1:0] WA_RD    = 2'b01;
    localparam logic [1:0] WA_RA    = 2'b10;

    localparam logic [1:0] RES_MEM  = 2'b00;
    localparam logic [1:0] RES_ALU  = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_BR    = 2'b01;
    localparam logic [1:0] PC_JUMP  = 2'b10;
    localparam logic [1:0] PC_REG   = 2'b11;

    logic       rf_we_d,      rf_we_q;
    logic [1:0] sel_wa_d,     sel_wa_q;
    logic       sel_alu_b_d,  sel_alu_b_q;
    logic       dmem_we_d,    dmem_we_q;
    logic [1:0] sel_result_d, sel_result_q;
    logic [1:0] sel_pc_d,     sel_pc_q;
    alu_op_e    alu_ctrl_d,   alu_ctrl_q;

    // Combinational decode. Every output starts from the safe NOP word, so
    // any opcode or funct not listed below falls through to "no write,
    // PC+4, ALU add" and no latch can be inferred.
    always_comb begin
        rf_we_d      = 1'b0;
        sel_wa_d     = WA_RT;
        sel_alu_b_d  = 1'b0;
        dmem_we_d    = 1'b0;
        sel_result_d = RES_ALU;
        sel_pc_d     = PC_PLUS4;
        alu_ctrl_d   = ALU_ADD;

        case (opcode_i)
            OP_LW: begin
                rf_we_d      = 1'b1;
                sel_alu_b_d  = 1'b1;
                sel_result_d = RES_MEM;
            end
            OP_SW: begin
                sel_alu_b_d  = 1'b1;
                dmem_we_d    = 1'b1;
            end
            OP_ADDI: begin
                rf_we_d      = 1'b1;
                sel_alu_b_d  = 1'b1;
            end
            OP_J: begin
                sel_pc_d     = PC_JUMP;
            end
            OP_JAL: begin
                rf_we_d      = 1'b1;
                sel_wa_d     = WA_RA;
                sel_result_d = RES_PC4;
                sel_pc_d     = PC_JUMP;
            end
            OP_BEQ: begin
                // The branch is resolved here from the zero flag, so the
                // PC mux only sees "taken" or "not taken".
                sel_pc_d     = zero_i ? PC_BR : PC_PLUS4;
                alu_ctrl_d   = ALU_SUB;
            end
            OP_RTYPE: begin
                if (funct_i == FN_JR) begin
                    sel_pc_d = PC_REG;
                end else begin
                    // Assume a recognised ALU funct; the default arm below
                    // takes the write enable back out for unknown codes.
                    rf_we_d  = 1'b1;
                    sel_wa_d = WA_RD;
                    case (funct_i)
                        6'h20, 6'h21: alu_ctrl_d = ALU_ADD;
                        6'h22, 6'h23: alu_ctrl_d = ALU_SUB;
                        6'h24:        alu_ctrl_d = ALU_AND;
                        6'h25:        alu_ctrl_d = ALU_OR;
                        6'h26:        alu_ctrl_d = ALU_XOR;
                        6'h27:        alu_ctrl_d = ALU_NOR;
                        6'h2A:        alu_ctrl_d = ALU_SLT;
                        6'h00:        alu_ctrl_d = ALU_SLL;
                        6'h02:        alu_ctrl_d = ALU_SRL;
                        6'h03:        alu_ctrl_d = ALU_SRA;
                        default: begin
                            rf_we_d    = 1'b0;
                            sel_wa_d   = WA_RT;
                            alu_ctrl_d = ALU_ADD;
                        end
                    endcase
                end
            end
            default: ;
        endcase
    end

    // Output registers. Reset clears them immediately, so neither write
    // enable can be high while reset_n_i is low.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rf_we_q      <= 1'b0;
            sel_wa_q     <= WA_RT;
            sel_alu_b_q  <= 1'b0;
            dmem_we_q    <= 1'b0;
            sel_result_q <= RES_MEM;
            sel_pc_q     <= PC_PLUS4;
            alu_ctrl_q   <= ALU_ADD;
        end else begin
            rf_we_q      <= rf_we_d;
            sel_wa_q     <= sel_wa_d;
            sel_alu_b_q  <= sel_alu_b_d;
            dmem_we_q    <= dmem_we_d;
            sel_result_q <= sel_result_d;
            sel_pc_q     <= sel_pc_d;
            alu_ctrl_q   <= alu_ctrl_d;
        end
    end

    assign rf_we_o      = rf_we_q;
    assign sel_wa_o     = sel_wa_q;
    assign sel_alu_b_o  = sel_alu_b_q;
    assign dmem_we_o    = dmem_we_q;
    assign sel_result_o = sel_result_q;
    assign sel_pc_o     = sel_pc_q;
    assign alu_ctrl_o   = alu_ctrl_q;

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
//
// Testbench for control_unit. An instruction-level model predicts the
// registered control word from the inputs seen at each rising edge, and the
// DUT is compared against it on every falling edge. Directed vectors also
// carry hand-computed control words.
// ---------------------------------------------------------------------------
module tb_control_unit;

    logic       clock;
    logic       reset_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       rfWe;
    logic [1:0] selWa;
    logic       selAluB;
    logic       dmemWe;
    logic [1:0] selResult;
    logic [1:0] selPc;
    logic [3:0] aluCtrl;

    int checkCount = 0;
    int failCount  = 0;

    logic [12:0] expWord;
    bit          modelValid = 1'b0;

    wire [8:0] dutCtrl = {rfWe, selWa, selAluB, dmemWe, selResult, selPc};

    control_unit dut (
        .clock_i      (clock),
        .reset_n_i    (reset_n),
        .opcode_i     (opcode),
        .funct_i      (funct),
        .zero_i       (zero),
        .rf_we_o      (rfWe),
        .sel_wa_o     (selWa),
        .sel_alu_b_o  (selAluB),
        .dmem_we_o    (dmemWe),
        .sel_result_o (selResult),
        .sel_pc_o     (selPc),
        .alu_ctrl_o   (aluCtrl)
    );

    // 10 ns clock period
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: describe each instruction by what it does (writes a register?
    // which one? from where? touches memory? where does the PC go?) and
    // build the expected control word from those facts.
    function automatic logic [12:0] expectedWord(input logic [5:0] op,
                                                 input logic [5:0] fn,
                                                 input logic       z);
        bit         writesReg   = 0;
        int         destReg     = 0;
        bit         usesImm     = 0;
        bit         writesMem   = 0;
        int         resultFrom  = 1;
        int         nextPc      = 0;
        logic [3:0] aluOp       = 4'd2;
        logic [8:0] ctrl;
        if (op == 6'd35) begin
            writesReg = 1; usesImm = 1; resultFrom = 0;
        end else if (op == 6'd43) begin
            usesImm = 1; writesMem = 1;
        end else if (op == 6'd8) begin
            writesReg = 1; usesImm = 1;
        end else if (op == 6'd2) begin
            nextPc = 2;
        end else if (op == 6'd3) begin
            writesReg = 1; destReg = 2; resultFrom = 2; nextPc = 2;
        end else if (op == 6'd4) begin
            nextPc = z ? 1 : 0; aluOp = 4'd6;
        end else if (op == 6'd0) begin
            if (fn == 6'd8) begin
                nextPc = 3;
            end else begin
                writesReg = 1; destReg = 1;
                if (fn == 6'd32 || fn == 6'd33)      aluOp = 4'd2;
                else if (fn == 6'd34 || fn == 6'd35) aluOp = 4'd6;
                else if (fn == 6'd36)                aluOp = 4'd0;
                else if (fn == 6'd37)                aluOp = 4'd1;
                else if (fn == 6'd38)                aluOp = 4'd3;
                else if (fn == 6'd39)                aluOp = 4'd4;
                else if (fn == 6'd42)                aluOp = 4'd7;
                else if (fn == 6'd0)                 aluOp = 4'd8;
                else if (fn == 6'd2)                 aluOp = 4'd9;
                else if (fn == 6'd3)                 aluOp = 4'd10;
                else begin
                    writesReg = 0; destReg = 0;
                end
            end
        end
        ctrl = {writesReg, 2'(destReg), usesImm, writesMem,
                2'(resultFrom), 2'(nextPc)};
        return {ctrl, aluOp};
    endfunction

    // Model register: reset gives the all-zero word with ALU add, otherwise
    // capture the prediction from the inputs present at the rising edge.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) expWord = {9'b0, 4'b0010};
        else          expWord = expectedWord(opcode, funct, zero);
        modelValid = 1'b1;
    end

    // Continuous compare against the model, mid-cycle.
    always @(negedge clock) begin
        if (modelValid) begin
            checkCount++;
            if ({dutCtrl, aluCtrl} !== expWord) begin
                failCount++;
                $display("[TB] FAIL model_cmp t=%0t op=%h fn=%h: got ctrl=%b alu=%b, expected ctrl=%b alu=%b",
                         $time, opcode, funct, dutCtrl, aluCtrl,
                         expWord[12:4], expWord[3:0]);
            end
        end
    end

    // Drive one instruction and advance to just after the next rising edge.
    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                                 input logic z);
        opcode = op;
        funct  = fn;
        zero   = z;
        @(posedge clock);
        #1;
    endtask

    // Compare the registered outputs with a hand-computed control word.
    task automatic checkOutput(input string name, input logic [8:0] expCtrl,
                               input logic [3:0] expAlu);
        checkCount++;
        if (dutCtrl !== expCtrl || aluCtrl !== expAlu) begin
            failCount++;
            $display("[TB] FAIL %s: got ctrl=%b alu=%b, expected ctrl=%b alu=%b",
                     name, dutCtrl, aluCtrl, expCtrl, expAlu);
        end
    endtask

    // Directed sequence.
    initial begin
        logic [5:0] sweepFn  [9];
        logic [3:0] sweepAlu [9];
        sweepFn  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h02, 6'h03};
        sweepAlu = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011, 4'b0100,
                     4'b0111, 4'b1001, 4'b1010};

        reset_n = 1'b0;
        opcode  = 6'h23;
        funct   = 6'h00;
        zero    = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_hold", 9'b0_00_0_0_00_00, 4'b0010);

        reset_n = 1'b1;
        applyStimulus(6'h00, 6'h00, 1'b0);
        checkOutput("first_sll", 9'b1_01_0_0_01_00, 4'b1000);

        applyStimulus(6'h23, 6'h3F, 1'b0);
        checkOutput("lw", 9'b1_00_1_0_00_00, 4'b0010);
        applyStimulus(6'h2B, 6'h00, 1'b1);
        checkOutput("sw", 9'b0_00_1_1_01_00, 4'b0010);
        applyStimulus(6'h08, 6'h08, 1'b0);
        checkOutput("addi", 9'b1_00_1_0_01_00, 4'b0010);

        applyStimulus(6'h02, 6'h00, 1'b0);
        checkOutput("j", 9'b0_00_0_0_01_10, 4'b0010);
        applyStimulus(6'h03, 6'h00, 1'b0);
        checkOutput("jal", 9'b1_10_0_0_10_10, 4'b0010);
        applyStimulus(6'h00, 6'h08, 1'b0);
        checkOutput("jr", 9'b0_00_0_0_01_11, 4'b0010);

        applyStimulus(6'h04, 6'h00, 1'b0);
        checkOutput("beq_nz", 9'b0_00_0_0_01_00, 4'b0110);
        applyStimulus(6'h04, 6'h00, 1'b1);
        checkOutput("beq_z", 9'b0_00_0_0_01_01, 4'b0110);
        // Change zero after the edge: the output must keep the sampled value
        zero = 1'b0;
        #2;
        checkOutput("beq_hold", 9'b0_00_0_0_01_01, 4'b0110);
        @(posedge clock);
        #1;
        checkOutput("beq_resample", 9'b0_00_0_0_01_00, 4'b0110);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(6'h00, sweepFn[i], 1'b0);
            checkOutput($sformatf("rtype_fn%h", sweepFn[i]),
                        9'b1_01_0_0_01_00, sweepAlu[i]);
        end
        applyStimulus(6'h00, 6'h21, 1'b1);
        checkOutput("addu", 9'b1_01_0_0_01_00, 4'b0010);
        applyStimulus(6'h00, 6'h23, 1'b0);
        checkOutput("subu", 9'b1_01_0_0_01_00, 4'b0110);

        applyStimulus(6'h3F, 6'h20, 1'b1);
        checkOutput("illegal_op", 9'b0_00_0_0_01_00, 4'b0010);
        applyStimulus(6'h00, 6'h3F, 1'b0);
        checkOutput("illegal_fn", 9'b0_00_0_0_01_00, 4'b0010);
        applyStimulus(6'h04, 6'h20, 1'b1);
        checkOutput("beq_ignores_fn", 9'b0_00_0_0_01_01, 4'b0110);

        // Mid-stream reset while a store is registered
        applyStimulus(6'h2B, 6'h00, 1'b0);
        checkOutput("sw_before_reset", 9'b0_00_1_1_01_00, 4'b0010);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("async_reset", 9'b0_00_0_0_00_00, 4'b0010);
        @(posedge clock);
        #1;
        checkOutput("reset_over_edge", 9'b0_00_0_0_00_00, 4'b0010);
        reset_n = 1'b1;
        applyStimulus(6'h03, 6'h00, 1'b0);
        checkOutput("jal_after_reset", 9'b1_10_0_0_10_10, 4'b0010);

        @(posedge clock);
        #6;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checkCount, failCount);
        $finish;
    end

endmodule
